// File: rtl/fft_frame_loader.sv
// fft_frame_loader: waits for a full FFT frame in the upstream FIFO, then
// drains it in FFT_SIZE back-to-back cycles. Each sample is tagged with its
// index within the frame, plus start-of-frame and end-of-frame flags.
// Optional build macro FFT_FRAME_LOADER_STATS_EN adds the o_frame_count and
// o_underrun_count status outputs.
module fft_frame_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int FFT_SIZE   = 64,
  parameter int FIFO_DEPTH = 128,
  parameter int GAP_CYCLES = 0,
  localparam int WCW = $clog2(FIFO_DEPTH + 1),
  localparam int IW  = $clog2(FFT_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_clr_err,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic [WCW-1:0]        i_fifo_word_count,
  output logic                  o_fifo_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [IW-1:0]         o_index,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_busy,
  output logic                  o_underrun
`ifdef FFT_FRAME_LOADER_STATS_EN
  ,
  output logic [15:0]           o_frame_count,
  output logic [7:0]            o_underrun_count
`endif
);

  // Occupancy compare width: wide enough for FFT_SIZE+1 regardless of WCW
  localparam int CMPW = (WCW > IW + 2) ? WCW : IW + 2;
  localparam logic [IW-1:0]   LAST_IDX = IW'(FFT_SIZE - 1);
  localparam logic [7:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [CMPW-1:0] FULL_LVL = CMPW'(FFT_SIZE);
  localparam logic [CMPW-1:0] NEXT_LVL = CMPW'(FFT_SIZE + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   count, count_nxt;
  logic [7:0]      gap_cnt, gap_nxt;
  logic            pop;
  logic            underrun_evt;
  logic            frame_done;
  logic [CMPW-1:0] wc_ext;
  logic            full_frame;
  logic            full_next;

  // Output stage registers
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [IW-1:0]         idx_p1;
  logic                  sof_p1;
  logic                  eof_p1;
  logic                  busy_p1;
  logic                  underrun_p1;

  assign wc_ext     = CMPW'(i_fifo_word_count);
  assign full_frame = (wc_ext >= FULL_LVL);
  // One word leaves the FIFO on the frame-end pop, so a following frame needs one extra word
  assign full_next  = (wc_ext >= NEXT_LVL);

  // Next-state, pop strobe and event decode
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    gap_nxt      = gap_cnt;
    pop          = 1'b0;
    underrun_evt = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable && full_frame) begin
          state_nxt = BURST;
          count_nxt = '0;
        end
      end
      BURST: begin
        if (i_fifo_valid) begin
          pop       = 1'b1;
          count_nxt = count + IW'(1);
          if (count == LAST_IDX) begin
            frame_done = 1'b1;
            count_nxt  = '0;
            if (GAP_CYCLES > 0) begin
              state_nxt = GAP;
              gap_nxt   = GAP_LOAD;
            end else if (i_enable && full_next) begin
              state_nxt = BURST;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          // FIFO flushed mid-frame: abandon the partial frame
          underrun_evt = 1'b1;
          state_nxt    = IDLE;
          count_nxt    = '0;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign o_fifo_pop = pop;

  // Control state: FSM, sample counter, gap timer and busy flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      count   <= '0;
      gap_cnt <= 8'd0;
      busy_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      gap_cnt <= gap_nxt;
      busy_p1 <= (state_nxt != IDLE);
    end
  end

  // Output stage: capture the popped FIFO head and its frame tags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      sof_p1  <= 1'b0;
      eof_p1  <= 1'b0;
    end else begin
      vld_p1 <= pop;
      sof_p1 <= pop && (count == '0);
      eof_p1 <= pop && (count == LAST_IDX);
      if (pop) begin
        data_p1 <= i_fifo_data;
        idx_p1  <= count;
      end
    end
  end

  // Sticky underrun flag; a new underrun wins over a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underrun_p1 <= 1'b0;
    end else if (underrun_evt) begin
      underrun_p1 <= 1'b1;
    end else if (i_clr_err) begin
      underrun_p1 <= 1'b0;
    end
  end

  assign o_valid    = vld_p1;
  assign o_data     = data_p1;
  assign o_index    = idx_p1;
  assign o_sof      = sof_p1;
  assign o_eof      = eof_p1;
  assign o_busy     = busy_p1;
  assign o_underrun = underrun_p1;

`ifdef FFT_FRAME_LOADER_STATS_EN
  logic [15:0] frame_cnt_p1;
  logic [7:0]  underrun_cnt_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Completed-frame counter (wraps) and saturating underrun counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_p1    <= 16'd0;
      underrun_cnt_p1 <= 8'd0;
    end else begin
      if (frame_done) begin
        frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
      end
      if (underrun_evt) begin
        underrun_cnt_p1 <= sat_inc8(underrun_cnt_p1);
      end else if (i_clr_err) begin
        underrun_cnt_p1 <= 8'd0;
      end
    end
  end

  assign o_frame_count    = frame_cnt_p1;
  assign o_underrun_count = underrun_cnt_p1;
`endif

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Sits directly downstream of the input sample FIFO, which runs in valid/taken mode, and feeds the first butterfly stage of the pipelined FFT.
- Waits until the FIFO holds a full FFT frame, then drains exactly FFT_SIZE samples in consecutive cycles with no bubbles.
- Tags the output with sample index, start-of-frame and end-of-frame.
- Guarantees the FFT pipeline never sees a partial or gapped frame.

Parameters:
- DATA_WIDTH, 32, sample width in bits; must match the FIFO.
- FFT_SIZE, 64, samples per frame; power of two, >=2.
- FIFO_DEPTH, 128, depth of the upstream FIFO; >=FFT_SIZE; sets the word-count width WCW=$clog2(FIFO_DEPTH+1).
- GAP_CYCLES, 0, minimum idle cycles forced between frames (0..255).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  allow new frames to start; sampled only at frame boundaries.
- i_clr_err  in  1  synchronous clear of o_underrun.
- i_fifo_valid  in  1  FIFO non-empty / data valid.
- i_fifo_data  in  DATA_WIDTH  FIFO head word.
- i_fifo_word_count  in  WCW  FIFO occupancy.
- o_fifo_pop  out  1  taken strobe to FIFO; combinational.
- o_valid  out  1  output sample valid; registered.
- o_data  out  DATA_WIDTH  output sample; registered.
- o_index  out  $clog2(FFT_SIZE)  index of the sample within its frame, 0..FFT_SIZE-1; registered.
- o_sof  out  1  high with index 0; registered.
- o_eof  out  1  high with index FFT_SIZE-1; registered.
- o_busy  out  1  state != IDLE; registered.
- o_underrun  out  1  sticky error flag; registered.

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, gap counter=0, all registered outputs 0.
- FSM states: IDLE, BURST, GAP.

IDLE:
- If i_enable and i_fifo_word_count >= FFT_SIZE, go to BURST next cycle with count=0.
- The comparison is done at width max(WCW, $clog2(FFT_SIZE)+2) so it cannot overflow.

BURST:
- o_fifo_pop = (state==BURST) & i_fifo_valid.
- On each pop, next cycle: o_valid=1, o_data=i_fifo_data, o_index=count, o_sof=(count==0), o_eof=(count==FFT_SIZE-1); count increments.
- Latency: FIFO head to output is 1 cycle.
- On the pop with count==FFT_SIZE-1 (frame end), choose the next state in this priority:
  - GAP_CYCLES>0: go to GAP with gap counter=GAP_CYCLES-1.
  - GAP_CYCLES==0 and i_enable and i_fifo_word_count >= FFT_SIZE+1: stay in BURST with count=0, so frames run back-to-back. The +1 accounts for the word being popped this cycle.
  - Otherwise: go to IDLE.
- Underrun: BURST with i_fifo_valid=0 means the upstream FIFO was flushed mid-frame.
  - No pop, o_valid=0 next cycle, no o_eof.
  - o_underrun set; state goes to IDLE; count=0. The partial frame is abandoned.

GAP:
- Outputs idle.
- Gap counter decrements; at 0, go to IDLE.
- Total idle between o_eof and the next o_sof is >= GAP_CYCLES+1 cycles.

Other rules:
- o_valid, o_sof and o_eof are single-cycle pulses per sample; o_data and o_index hold their values while o_valid=0.
- i_enable deasserted mid-frame has no effect; the current frame completes.
- o_underrun: set has priority over i_clr_err in the same cycle; it is cleared only by i_clr_err or reset.
- Never pops in IDLE or GAP, so the FIFO never sees a pop error from this block.
- count width is $clog2(FFT_SIZE); it wraps naturally at FFT_SIZE-1.
- Reset mid-frame: outputs drop to 0 immediately; no completion of the frame.

Optional Feature:
- Macro: FFT_FRAME_LOADER_STATS_EN.
- When defined, adds two output ports:
  - o_frame_count, 16 bits: increments on each completed o_eof; wraps at 0xFFFF->0; cleared by reset.
  - o_underrun_count, 8 bits: increments on each underrun event; saturates at 0xFF; cleared by reset or i_clr_err.
- When not defined, neither port exists and no counter logic is generated.

Test Plan:
All scenarios use FFT_SIZE=8, DATA_WIDTH=16, FIFO_DEPTH=16.
1. GAP_CYCLES=0, enable=1, push 7 words (values 0x10..0x16) -> no pop. Push an 8th word 0x17 -> o_valid for 8 consecutive cycles carrying 0x10..0x17 with o_index 0..7, o_sof on the first, o_eof on the last.
2. GAP_CYCLES=0, FIFO preloaded with 16 words -> 16 consecutive o_valid cycles with no bubble. o_sof appears at the 1st and 9th outputs; o_eof at the 8th and 16th.
3. GAP_CYCLES=3, 16 words preloaded -> exactly 4 idle cycles between the first o_eof and the second o_sof; o_busy low only in the final idle cycle before the second BURST.
4. Mid-burst at index 4, flush the FIFO (i_fifo_valid=0) -> o_valid low next cycle, no o_eof, o_underrun=1. With STATS_EN, o_underrun_count=1. i_clr_err clears both. The next full frame starts at index 0.
5. Deassert i_enable at index 3 -> the frame completes through index 7 and no new frame starts. Deassert i_rst_n mid-frame -> all outputs 0 asynchronously, state IDLE.
6. With STATS_EN, stream 3 complete frames -> o_frame_count=3. Reset -> o_frame_count=0.
